// File: rtl/regfile_dbg_access.sv
// Debug read/write engine for the RV32I register file: halts the core, owns the
// regfile write and rs1 ports for one cycle, then returns data/status.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | core passthrough, ready for a command
// HALT_WAIT | halt requested, waiting for ack or timeout
// ACCESS    | one cycle of debug ownership of rf write/rs1 ports
// RESP      | response held until consumer takes it
module regfile_dbg_access #(
    parameter int unsigned HALT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_status,
    output logic        halt_req,
    input  logic        halt_ack,
    input  logic        core_we,
    input  logic [4:0]  core_rd,
    input  logic [31:0] core_wd,
    input  logic [4:0]  core_rs1,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wd,
    output logic [4:0]  rf_rs1,
    input  logic [31:0] rf_rd1
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HALT_WAIT = 2'd1,
        ACCESS    = 2'd2,
        RESP      = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(HALT_TIMEOUT - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic        lat_write;
    logic [4:0]  lat_addr;
    logic [31:0] lat_wdata;

    assign cmd_ready = (state == IDLE);

    // Debug owns the ports only in ACCESS; writes to x0 are suppressed.
    always_comb begin
        rf_we  = core_we;
        rf_rd  = core_rd;
        rf_wd  = core_wd;
        rf_rs1 = core_rs1;
        if (state == ACCESS) begin
            rf_we  = lat_write && (lat_addr != 5'd0);
            rf_rd  = lat_addr;
            rf_wd  = lat_wdata;
            rf_rs1 = lat_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            halt_req   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_status <= 2'b00;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        lat_write <= cmd_write;
                        lat_addr  <= cmd_addr;
                        lat_wdata <= cmd_wdata;
                        cnt       <= '0;
                        halt_req  <= 1'b1;
                        state     <= HALT_WAIT;
                    end
                end
                HALT_WAIT: begin
                    // An ack in the final timeout cycle still wins.
                    if (halt_ack) begin
                        state <= ACCESS;
                    end else if (cnt == CNT_LAST) begin
                        state      <= RESP;
                        halt_req   <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_status <= 2'b01;
                        rsp_rdata  <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ACCESS: begin
                    state      <= RESP;
                    halt_req   <= 1'b0;
                    rsp_valid  <= 1'b1;
                    rsp_status <= core_we ? 2'b10 : 2'b00;
                    rsp_rdata  <= (!lat_write && lat_addr != 5'd0) ? rf_rd1 : 32'd0;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dbg_access.sv
// Directed bench for regfile_dbg_access with a behavioural 32x32 regfile model
// behind the rf_* ports.
module tb_regfile_dbg_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;
    logic        halt_req, halt_ack;
    logic        core_we;
    logic [4:0]  core_rd, core_rs1;
    logic [31:0] core_wd;
    logic        rf_we;
    logic [4:0]  rf_rd, rf_rs1;
    logic [31:0] rf_wd, rf_rd1;

    int tests = 0;
    int fails = 0;
    int we_pulses = 0;

    logic [31:0] regs [32];

    regfile_dbg_access #(.HALT_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
        .halt_req(halt_req), .halt_ack(halt_ack),
        .core_we(core_we), .core_rd(core_rd), .core_wd(core_wd), .core_rs1(core_rs1),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd), .rf_rs1(rf_rs1), .rf_rd1(rf_rd1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else begin
            if (rf_we && rf_rd != 5'd0) regs[rf_rd] <= rf_wd;
            if (rf_we) we_pulses++;
        end
    end
    assign rf_rd1 = (rf_rs1 == 5'd0) ? 32'd0 : regs[rf_rs1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        cwe;
        logic [4:0]  crd;
        logic [31:0] cwd;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_status;
        int          exp_pulses;
        logic [4:0]  chk_addr;
        logic [31:0] chk_val;
    } vec_t;

    vec_t vecs [8];

    task automatic run_vec(input vec_t v);
        int p0;
        p0 = we_pulses;
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
        #1;
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        core_rs1 = 5'd12;
        #1;
        check("halt_req_wait", 32'(halt_req), 32'd1);
        check("cmd_ready_wait", 32'(cmd_ready), 32'd0);
        check("rs1_pass_wait", 32'(rf_rs1), 32'd12);
        core_rs1 = 5'd0;
        tick();
        core_we = v.cwe; core_rd = v.crd; core_wd = v.cwd;
        #1;
        check("access_we", 32'(rf_we), 32'(v.exp_pulses));
        if (v.wr) begin
            check("access_rd", 32'(rf_rd), 32'(v.addr));
            check("access_wd", rf_wd, v.wdata);
        end else begin
            check("access_rs1", 32'(rf_rs1), 32'(v.addr));
        end
        check("access_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        core_we = 1'b0;
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_rdata", rsp_rdata, v.exp_rdata);
        check("rsp_status", 32'(rsp_status), 32'(v.exp_status));
        check("halt_req_resp", 32'(halt_req), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
        check("cmd_ready_after_hs", 32'(cmd_ready), 32'd1);
        check("we_pulses", 32'(we_pulses - p0), 32'(v.exp_pulses));
        check("rf_model", regs[v.chk_addr], v.chk_val);
    endtask

    initial begin
        int hr, p0;
        vecs[0] = '{1'b1, 5'd5,  32'hA5A5_1234, 1'b0, 5'd0, 32'h0,         32'h0,         2'd0, 1, 5'd5,  32'hA5A5_1234};
        vecs[1] = '{1'b0, 5'd5,  32'h0,         1'b0, 5'd0, 32'h0,         32'hA5A5_1234, 2'd0, 0, 5'd5,  32'hA5A5_1234};
        vecs[2] = '{1'b1, 5'd0,  32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0,         32'h0,         2'd0, 0, 5'd0,  32'h0};
        vecs[3] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 32'h0,         32'h0,         2'd0, 0, 5'd0,  32'h0};
        vecs[4] = '{1'b1, 5'd3,  32'h3333_3333, 1'b1, 5'd7, 32'h1111_1111, 32'h0,         2'd2, 1, 5'd7,  32'h0};
        vecs[5] = '{1'b0, 5'd3,  32'h0,         1'b0, 5'd0, 32'h0,         32'h3333_3333, 2'd0, 0, 5'd3,  32'h3333_3333};
        vecs[6] = '{1'b0, 5'd5,  32'h0,         1'b1, 5'd9, 32'h9999_9999, 32'hA5A5_1234, 2'd2, 0, 5'd9,  32'h0};
        vecs[7] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0,         32'h0,         2'd0, 1, 5'd31, 32'hFFFF_FFFF};

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; halt_ack = 1'b1;
        core_we = 1'b0; core_rd = '0; core_wd = '0; core_rs1 = '0;
        tick(); tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_halt_req", 32'(halt_req), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_status", 32'(rsp_status), 32'd0);
        rst = 1'b0;
        tick();

        // IDLE passthrough of a core write and rs1
        core_we = 1'b1; core_rd = 5'd20; core_wd = 32'h2020_2020; core_rs1 = 5'd9;
        #1;
        check("idle_pass_we", 32'(rf_we), 32'd1);
        check("idle_pass_rd", 32'(rf_rd), 32'd20);
        check("idle_pass_wd", rf_wd, 32'h2020_2020);
        check("idle_pass_rs1", 32'(rf_rs1), 32'd9);
        tick();
        core_we = 1'b0; core_rs1 = 5'd0;
        check("idle_core_write", regs[20], 32'h2020_2020);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Timeout: no ack, halt_req high for exactly 4 cycles
        halt_ack = 1'b0;
        p0 = we_pulses;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd8; cmd_wdata = 32'h8888_8888;
        tick();
        cmd_valid = 1'b0;
        hr = 0;
        for (int c = 0; c < 20 && !rsp_valid; c++) begin
            if (halt_req) hr++;
            tick();
        end
        check("to_rsp_valid", 32'(rsp_valid), 32'd1);
        check("to_halt_cycles", 32'(hr), 32'd4);
        check("to_status", 32'(rsp_status), 32'd1);
        check("to_rdata", rsp_rdata, 32'd0);
        check("to_no_write", 32'(we_pulses - p0), 32'd0);
        check("to_x8", regs[8], 32'd0);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

        // Ack arriving in the last timeout cycle wins
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd5;
        tick();
        cmd_valid = 1'b0;
        tick(); tick(); tick();
        check("late_ack_wait", 32'(halt_req), 32'd1);
        check("late_ack_no_rsp", 32'(rsp_valid), 32'd0);
        halt_ack = 1'b1;
        tick(); tick();
        check("late_ack_rsp_valid", 32'(rsp_valid), 32'd1);
        check("late_ack_status", 32'(rsp_status), 32'd0);
        check("late_ack_rdata", rsp_rdata, 32'hA5A5_1234);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

        // Backpressure: response must hold while rf_rd1 moves underneath
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd31;
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        core_rs1 = 5'd5;
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rdata", rsp_rdata, 32'hFFFF_FFFF);
            check("bp_status", 32'(rsp_status), 32'd0);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        core_rs1 = 5'd0;
        check("bp_released", 32'(rsp_valid), 32'd0);

        // Reset during HALT_WAIT aborts silently
        halt_ack = 1'b0;
        p0 = we_pulses;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd6; cmd_wdata = 32'h6666_6666;
        tick();
        cmd_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid_halt_req", 32'(halt_req), 32'd0);
        check("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        halt_ack = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        check("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
        check("rst_mid_no_write", 32'(we_pulses - p0), 32'd0);
        check("rst_mid_x6", regs[6], 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
